// File: rtl/riscv_mem_arbiter_if.sv
// riscv_mem_arbiter_if: bundles the fetch port, the data port and the
// shared memory port seen by riscv_mem_arbiter.
// slave  : arbiter side (takes requests, drives memory)
// master : environment side (pipeline fetch/MEM stages plus memory model)
interface riscv_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  // fetch port
  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_stall;
  logic                  i_valid;
  logic [31:0]           i_rdata;
  // data port
  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [31:0]           d_wdata;
  logic                  d_stall;
  logic                  d_valid;
  logic [31:0]           d_rdata;
  // unified memory port
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_re;
  logic                  mem_we;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;

  modport slave (
    input  i_req, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata,
    output i_stall, i_valid, i_rdata, d_stall, d_valid, d_rdata,
           mem_addr, mem_re, mem_we, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata,
    input  i_stall, i_valid, i_rdata, d_stall, d_valid, d_rdata,
           mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one synchronous-read memory between the fetch
// port and the load/store port. Data wins by default; the loser stalls.
// Read responses (1-cycle latency) are steered back to the issuing port.
// Optional macro MEM_ARB_FAIR_EN: after MAX_STARVE consecutive stalled fetch
// cycles, fetch wins for one cycle so it cannot starve forever.
module riscv_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_STARVE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  riscv_mem_arbiter_if.slave    bus,
  output logic                  err,
  output logic [31:0]           cnt_igrant,
  output logic [31:0]           cnt_dgrant,
  output logic [31:0]           cnt_stall
);

  typedef enum logic [1:0] {RSP_NONE, RSP_I, RSP_D} rsp_state_t;

  rsp_state_t rsp_state;
  logic       d_req;
  logic       both_rw;
  logic       grant_i;
  logic       grant_d;
  logic       d_load;

  assign d_req   = bus.d_read | bus.d_write;
  assign both_rw = bus.d_read & bus.d_write;
  // a simultaneous read+write is executed as a store only
  assign d_load  = bus.d_read & ~bus.d_write;

`ifdef MEM_ARB_FAIR_EN
  logic [31:0] starve_cnt;
  logic        force_i;

  assign force_i = bus.i_req && (starve_cnt == 32'(MAX_STARVE));
  assign grant_d = d_req & ~force_i;
  assign grant_i = bus.i_req & ~grant_d;

  // count consecutive stalled fetch cycles; any fetch grant or idle fetch clears it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!bus.i_req || grant_i) begin
      starve_cnt <= '0;
    end else if (bus.i_stall) begin
      starve_cnt <= starve_cnt + 32'd1;
    end
  end
`else
  assign grant_d = d_req;
  assign grant_i = bus.i_req & ~d_req;
`endif

  // stalls are combinational but forced low while reset is asserted
  assign bus.i_stall = rst & bus.i_req & ~grant_i;
  assign bus.d_stall = rst & d_req & ~grant_d;

  // winner drives the memory port; idle cycles park the port at zero
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    if (grant_d) begin
      bus.mem_addr  = bus.d_addr;
      bus.mem_re    = d_load;
      bus.mem_we    = bus.d_write;
      bus.mem_wdata = bus.d_wdata;
    end else if (grant_i) begin
      bus.mem_addr  = bus.i_addr;
      bus.mem_re    = 1'b1;
    end
  end

  // response FSM remembers who owns the read issued this cycle, with registered valids
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_state   <= RSP_NONE;
      bus.i_valid <= 1'b0;
      bus.d_valid <= 1'b0;
    end else begin
      if (grant_i) begin
        rsp_state   <= RSP_I;
        bus.i_valid <= 1'b1;
        bus.d_valid <= 1'b0;
      end else if (grant_d && d_load) begin
        rsp_state   <= RSP_D;
        bus.i_valid <= 1'b0;
        bus.d_valid <= 1'b1;
      end else begin
        rsp_state   <= RSP_NONE;
        bus.i_valid <= 1'b0;
        bus.d_valid <= 1'b0;
      end
    end
  end

  // read data goes only to the owner of the response; the other port sees zero
  assign bus.i_rdata = (rsp_state == RSP_I) ? bus.mem_rdata : 32'd0;
  assign bus.d_rdata = (rsp_state == RSP_D) ? bus.mem_rdata : 32'd0;

  // sticky protocol error and wrapping performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err        <= 1'b0;
      cnt_igrant <= '0;
      cnt_dgrant <= '0;
      cnt_stall  <= '0;
    end else begin
      if (both_rw) err <= 1'b1;
      if (grant_i) cnt_igrant <= cnt_igrant + 32'd1;
      if (grant_d) cnt_dgrant <= cnt_dgrant + 32'd1;
      if (bus.i_stall || bus.d_stall) cnt_stall <= cnt_stall + 32'd1;
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: directed self-checking bench for riscv_mem_arbiter.
// Expectations follow the MEM_ARB_FAIR_EN setting of the build.
module tb_riscv_mem_arbiter;

  localparam int ADDR_WIDTH = 32;
  localparam int MAX_STARVE = 4;

  logic        clk;
  logic        rst;
  logic        err;
  logic [31:0] cnt_igrant;
  logic [31:0] cnt_dgrant;
  logic [31:0] cnt_stall;

  int assertCount = 0;
  int failCount   = 0;

  riscv_mem_arbiter_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

  riscv_mem_arbiter #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .MAX_STARVE(MAX_STARVE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .err        (err),
    .cnt_igrant (cnt_igrant),
    .cnt_dgrant (cnt_dgrant),
    .cnt_stall  (cnt_stall)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous-read memory model, one cycle read latency
  logic [31:0] mem [logic [31:0]];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 32'd0;
  end

  // count a comparison and report any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // drive one cycle of requests, then let combinational outputs settle
  task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                               input logic dr, input logic dw,
                               input logic [31:0] daddr, input logic [31:0] wdata);
    bus.i_req   = ireq;
    bus.i_addr  = iaddr;
    bus.d_read  = dr;
    bus.d_write = dw;
    bus.d_addr  = daddr;
    bus.d_wdata = wdata;
    #1;
  endtask

  // advance to just after the next rising edge
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  int expIgrant;
  int expDgrant;

  initial begin
    mem[32'h0000_0000] = 32'h0000_0013;
    mem[32'h0000_0004] = 32'h0010_0093;
    mem[32'h0000_2000] = 32'h1111_2222;
    bus.mem_rdata = 32'd0;
    rst = 1'b0;

    // reset state, with conflicting requests to exercise stall masking
    applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h2000, 32'h0);
    nextCycle();
    checkOutput("rst_i_stall_masked", {31'd0, bus.i_stall}, 32'd0);
    checkOutput("rst_i_valid", {31'd0, bus.i_valid}, 32'd0);
    checkOutput("rst_d_valid", {31'd0, bus.d_valid}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    checkOutput("rst_cnt_igrant", cnt_igrant, 32'd0);
    checkOutput("rst_cnt_stall", cnt_stall, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
    rst = 1'b1;

    // single fetch: grant now, response next cycle
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("f1_mem_re", {31'd0, bus.mem_re}, 32'd1);
    checkOutput("f1_mem_addr", bus.mem_addr, 32'h0);
    checkOutput("f1_i_stall", {31'd0, bus.i_stall}, 32'd0);
    checkOutput("f1_i_valid_early", {31'd0, bus.i_valid}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("f1_i_valid", {31'd0, bus.i_valid}, 32'd1);
    checkOutput("f1_i_rdata", bus.i_rdata, 32'h0000_0013);
    checkOutput("f1_d_valid", {31'd0, bus.d_valid}, 32'd0);
    checkOutput("f1_cnt_igrant", cnt_igrant, 32'd1);
    checkOutput("idle_mem_addr", bus.mem_addr, 32'h0);
    nextCycle();
    checkOutput("f1_i_valid_pulse", {31'd0, bus.i_valid}, 32'd0);

    // fetch and load together: load first, fetch the following cycle
    applyStimulus(1'b1, 32'h4, 1'b1, 1'b0, 32'h2000, 32'h0);
    checkOutput("c_d_stall", {31'd0, bus.d_stall}, 32'd0);
    checkOutput("c_i_stall", {31'd0, bus.i_stall}, 32'd1);
    checkOutput("c_mem_addr", bus.mem_addr, 32'h2000);
    nextCycle();
    applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("c_d_valid", {31'd0, bus.d_valid}, 32'd1);
    checkOutput("c_d_rdata", bus.d_rdata, 32'h1111_2222);
    checkOutput("c_i_rdata_zero", bus.i_rdata, 32'd0);
    checkOutput("c_i_stall_after", {31'd0, bus.i_stall}, 32'd0);
    checkOutput("c_fetch_addr", bus.mem_addr, 32'h4);
    checkOutput("c_cnt_stall", cnt_stall, 32'd1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("c_i_valid", {31'd0, bus.i_valid}, 32'd1);
    checkOutput("c_i_rdata", bus.i_rdata, 32'h0010_0093);
    checkOutput("c_d_rdata_zero", bus.d_rdata, 32'd0);
    checkOutput("c_cnt_igrant", cnt_igrant, 32'd2);
    checkOutput("c_cnt_dgrant", cnt_dgrant, 32'd1);

    // store then load same address: new data returned, no fetch response
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h2004, 32'hDEAD_BEEF);
    checkOutput("s_mem_we", {31'd0, bus.mem_we}, 32'd1);
    checkOutput("s_mem_re", {31'd0, bus.mem_re}, 32'd0);
    checkOutput("s_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h2004, 32'h0);
    checkOutput("s_no_d_valid", {31'd0, bus.d_valid}, 32'd0);
    checkOutput("s_mem_we_off", {31'd0, bus.mem_we}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("s_d_valid", {31'd0, bus.d_valid}, 32'd1);
    checkOutput("s_d_rdata", bus.d_rdata, 32'hDEAD_BEEF);
    checkOutput("s_i_valid", {31'd0, bus.i_valid}, 32'd0);
    nextCycle();

    // read and write together: sticky error, executed as a store
    checkOutput("e_err_before", {31'd0, err}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h2008, 32'h0000_0055);
    checkOutput("e_mem_we", {31'd0, bus.mem_we}, 32'd1);
    checkOutput("e_mem_re", {31'd0, bus.mem_re}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("e_err_set", {31'd0, err}, 32'd1);
    checkOutput("e_no_d_valid", {31'd0, bus.d_valid}, 32'd0);
    nextCycle();
    checkOutput("e_err_sticky", {31'd0, err}, 32'd1);
    checkOutput("e_cnt_dgrant", cnt_dgrant, 32'd4);

    // continuous loads plus fetch: starvation behaviour
    expIgrant = 2;
    expDgrant = 4;
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h2000, 32'h0);
`ifdef MEM_ARB_FAIR_EN
      checkOutput($sformatf("st_i_stall_%0d", k), {31'd0, bus.i_stall}, (k == MAX_STARVE + 1) ? 32'd0 : 32'd1);
      checkOutput($sformatf("st_d_stall_%0d", k), {31'd0, bus.d_stall}, (k == MAX_STARVE + 1) ? 32'd1 : 32'd0);
      if (k == MAX_STARVE + 1) expIgrant++; else expDgrant++;
`else
      checkOutput($sformatf("st_i_stall_%0d", k), {31'd0, bus.i_stall}, 32'd1);
      checkOutput($sformatf("st_d_stall_%0d", k), {31'd0, bus.d_stall}, 32'd0);
      expDgrant++;
`endif
      nextCycle();
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("st_cnt_igrant", cnt_igrant, 32'(expIgrant));
    checkOutput("st_cnt_dgrant", cnt_dgrant, 32'(expDgrant));
    checkOutput("st_cnt_stall", cnt_stall, 32'd7);
    nextCycle();

    // reset right after a fetch grant drops the pending response
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("r_i_valid_in_rst", {31'd0, bus.i_valid}, 32'd0);
    nextCycle();
    rst = 1'b1;
    #1;
    checkOutput("r_i_valid_release", {31'd0, bus.i_valid}, 32'd0);
    nextCycle();
    checkOutput("r_i_valid_after", {31'd0, bus.i_valid}, 32'd0);
    checkOutput("r_cnt_igrant", cnt_igrant, 32'd0);
    checkOutput("r_cnt_dgrant", cnt_dgrant, 32'd0);
    checkOutput("r_cnt_stall", cnt_stall, 32'd0);
    checkOutput("r_err", {31'd0, err}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/riscv_mem_arbiter.md
# riscv_mem_arbiter

Single-port memory arbiter for the basic RISC-V pipeline. It shares one unified synchronous-read memory between the instruction-fetch port and the data (load/store) port, and stalls whichever requester loses. It routes each 1-cycle-latency read response back to the port that issued it, and keeps grant/stall performance counters. It sits between `riscv_basic_pipeline` (fetch and MEM stages) and the memory model or BRAM.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: byte-address width on all ports.
- `MAX_STARVE`, 4: consecutive lost fetch cycles before fetch is forced to win. Used only with `MEM_ARB_FAIR_EN`.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  fetch request; held until `i_stall`=0.
- `i_addr`  in  ADDR_WIDTH  fetch address.
- `i_stall`  out  1  fetch request pending but not granted this cycle.
- `i_valid`  out  1  `i_rdata` valid (fetch response).
- `i_rdata`  out  32  fetch read data.
- `d_read`  in  1  load request.
- `d_write`  in  1  store request.
- `d_addr`  in  ADDR_WIDTH  data address.
- `d_wdata`  in  32  store data.
- `d_stall`  out  1  data request pending but not granted.
- `d_valid`  out  1  `d_rdata` valid (load response).
- `d_rdata`  out  32  load data.
- `mem_addr`  out  ADDR_WIDTH  memory address.
- `mem_re`  out  1  memory read enable.
- `mem_we`  out  1  memory write enable.
- `mem_wdata`  out  32  memory write data.
- `mem_rdata`  in  32  memory read data, valid the cycle after `mem_re`.
- `err`  out  1  sticky protocol error.
- `cnt_igrant`  out  32  fetch grants.
- `cnt_dgrant`  out  32  data grants.
- `cnt_stall`  out  32  cycles with `i_stall` or `d_stall` high.

## Operation
- Grant is combinational each cycle. Data request (`d_read|d_write`) beats `i_req`; `i_req` alone is granted; with no request, `mem_re`=`mem_we`=0 and `mem_addr`=0.
- Granted port drives `mem_addr`/`mem_re`/`mem_we`/`mem_wdata`. The loser sees its stall output = 1, and its request/address must stay stable.
- Response FSM registers the owner of the read issued this cycle: `RSP_NONE`, `RSP_I`, `RSP_D`.
  - Fetch read granted → next state `RSP_I`.
  - Load granted → next state `RSP_D`.
  - Store or no grant → next state `RSP_NONE`.
- In `RSP_I`, `i_valid`=1 and `i_rdata`=`mem_rdata`. In `RSP_D`, `d_valid`=1 and `d_rdata`=`mem_rdata`. Non-owner rdata = 0.
- A new access may issue in the same cycle as a response, giving one access per cycle.
- Stores complete in the grant cycle and produce no `d_valid`.
- `d_read` & `d_write` together sets `err`. The request is treated as a store only (`mem_we`=1, `mem_re`=0, no `d_valid`). `err` is cleared only by reset.
- Counters increment by 1 per qualifying cycle and wrap from 0xFFFFFFFF to 0.

## Timing
- Reset (`rst`=0, asynchronous):
  - FSM → `RSP_NONE`.
  - `i_valid`=`d_valid`=0, `err`=0, all counters 0, starve counter 0.
  - Stall outputs remain combinational but masked to 0 while `rst`=0.
- Read latency: grant in cycle N → valid for one cycle in N+1.
- Reset asserted with a read outstanding: the response is dropped, and no valid appears after reset release.
- Fetch and load both pending in cycle N: load granted in N, `d_valid` in N+1. Fetch granted in N+1 if data is idle, with `i_valid` in N+2.
- Store followed by a load to the same address in the next cycle returns the new data (memory ordering is preserved because there is one port).

## Configuration
- `MEM_ARB_FAIR_EN` defined:
  - A starve counter increments each cycle `i_stall`=1. It clears on a fetch grant or when `i_req`=0.
  - When it equals `MAX_STARVE`, fetch wins over data that cycle and the data port stalls.
- Not defined: strict data priority. The starve counter is absent, and fetch can be stalled indefinitely.

## Test plan
- Reset then `i_req`=1, `i_addr`=0x0 with `mem_rdata`=0x00000013 → `mem_re`=1 in cycle 1, `i_valid`=1 and `i_rdata`=0x00000013 in cycle 2, `cnt_igrant`=1.
- Simultaneous `i_req` and `d_read` at `d_addr`=0x2000 → `d_stall`=0, `i_stall`=1, `mem_addr`=0x2000. Next cycle `d_valid`=1, fetch granted, `cnt_stall`=1.
- Store 0xDEADBEEF to 0x2004, then load 0x2004 the next cycle → `mem_we` pulse, then `d_rdata`=0xDEADBEEF; `i_valid` never asserted.
- `d_read`=`d_write`=1 for one cycle → `err`=1 and stays 1; `mem_we`=1, `mem_re`=0, no `d_valid`.
- `MEM_ARB_FAIR_EN`, `MAX_STARVE`=4, continuous data requests plus `i_req` → fetch granted on the 5th cycle with `d_stall`=1 that cycle; without the macro, fetch is never granted.
- Assert `rst`=0 the cycle after a fetch grant → `i_valid` stays 0, counters read 0 after release.
